// File: rtl/uart_rx_deserializer_pkg.sv
// Shared constants and types for the UART receive path.
// Also holds the helper that turns a raw prescale input into a legal oversampling ratio.
package uart_rx_deserializer_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int PRESCALE_W   = 6;
    localparam int MIN_PRESCALE = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Ratios below the minimum are raised to it; odd ratios are rounded down to even.
    function automatic logic [PRESCALE_W-1:0] legalize_prescale(input logic [PRESCALE_W-1:0] p);
        if (p < PRESCALE_W'(MIN_PRESCALE))
            return PRESCALE_W'(MIN_PRESCALE);
        else
            return {p[PRESCALE_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_sampler.sv
// Per-bit timing for the receiver: edge counter, three-point sampling around mid-bit and majority vote.
// The third sample is taken live, so the voted bit and sample_done are ready while the counter sits at P/2+1.
module rx_bit_sampler
    import uart_rx_deserializer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_run,
    input  logic                  i_rx_s,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_bit,
    output logic                  o_sample_done,
    output logic                  o_bit_end
);

    logic [PRESCALE_W-1:0] r_edgeCnt;
    logic [PRESCALE_W-1:0] w_half;
    logic                  r_smpEarly;
    logic                  r_smpMid;

    assign w_half        = i_prescale >> 1;
    assign o_sample_done = i_run && (r_edgeCnt == w_half + PRESCALE_W'(1));
    assign o_bit_end     = i_run && (r_edgeCnt == i_prescale - PRESCALE_W'(1));
    assign o_bit         = (r_smpEarly & r_smpMid) | (r_smpEarly & i_rx_s) | (r_smpMid & i_rx_s);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_edgeCnt  <= '0;
            r_smpEarly <= 1'b1;
            r_smpMid   <= 1'b1;
        end else begin
            if (!i_run || o_bit_end)
                r_edgeCnt <= '0;
            else
                r_edgeCnt <= r_edgeCnt + PRESCALE_W'(1);
            if (i_run && (r_edgeCnt == w_half - PRESCALE_W'(1)))
                r_smpEarly <= i_rx_s;
            if (i_run && (r_edgeCnt == w_half))
                r_smpMid <= i_rx_s;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes the line, frames start/data/parity/stop bits
// and emits the received word with single-cycle valid / parity-error / stop-error pulses.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_rx_in,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic [DATA_WIDTH-1:0] o_p_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_stp_err
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

    logic [1:0]            r_rxSync;
    logic                  w_rxS;
    rx_state_e             r_state;
    rx_state_e             w_nextState;
    logic                  r_armed;
    logic                  w_startDet;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_parEn;
    logic                  r_parTyp;
    logic [BIT_CNT_W-1:0]  r_bitCnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parFail;
    logic [DATA_WIDTH-1:0] r_pData;
    logic                  r_dataValid;
    logic                  r_parErr;
    logic                  r_stpErr;
    logic                  w_bit;
    logic                  w_sampleDone;
    logic                  w_bitEnd;
    logic                  w_expPar;

    assign w_rxS      = r_rxSync[1];
    assign w_startDet = (r_state == IDLE) && r_armed && !w_rxS;
    assign w_expPar   = (^r_shift) ^ (r_parTyp == PAR_ODD);

    assign o_p_data     = r_pData;
    assign o_data_valid = r_dataValid;
    assign o_par_err    = r_parErr;
    assign o_stp_err    = r_stpErr;

    rx_bit_sampler u_sampler (
        .i_clk         (i_clk),
        .i_resetn      (i_resetn),
        .i_run         (r_state != IDLE),
        .i_rx_s        (w_rxS),
        .i_prescale    (r_prescale),
        .o_bit         (w_bit),
        .o_sample_done (w_sampleDone),
        .o_bit_end     (w_bitEnd)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rxSync <= 2'b11;
            r_state  <= IDLE;
        end else begin
            r_rxSync <= {r_rxSync[0], i_rx_in};
            r_state  <= w_nextState;
        end
    end

    // The stop bit is judged at mid-bit so a slightly fast transmitter can start its next frame early.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_startDet) w_nextState = START;
            START:   if (w_sampleDone && w_bit) w_nextState = IDLE;
                     else if (w_bitEnd) w_nextState = DATA;
            DATA:    if (w_bitEnd && (r_bitCnt == BIT_CNT_W'(DATA_WIDTH - 1)))
                         w_nextState = r_parEn ? PARITY : STOP;
            PARITY:  if (w_bitEnd) w_nextState = STOP;
            STOP:    if (w_sampleDone) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Armed only tracks a high line while idle, so a held-low break cannot retrigger frames.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_armed     <= 1'b0;
            r_prescale  <= PRESCALE_W'(MIN_PRESCALE);
            r_parEn     <= 1'b0;
            r_parTyp    <= PAR_EVEN;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parFail   <= 1'b0;
            r_pData     <= '0;
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
        end else begin
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
            r_armed     <= (r_state == IDLE) ? w_rxS : 1'b0;
            if (w_startDet) begin
                r_prescale <= legalize_prescale(i_prescale);
                r_parEn    <= i_par_en;
                r_parTyp   <= i_par_typ;
                r_bitCnt   <= '0;
                r_parFail  <= 1'b0;
            end
            if ((r_state == DATA) && w_sampleDone)
                r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
            if ((r_state == DATA) && w_bitEnd)
                r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
            if ((r_state == PARITY) && w_sampleDone)
                r_parFail <= (w_bit != w_expPar);
            if ((r_state == STOP) && w_sampleDone) begin
                r_stpErr <= !w_bit;
                r_parErr <= r_parFail;
                if (w_bit && !r_parFail) begin
                    r_pData     <= r_shift;
                    r_dataValid <= 1'b1;
                end
            end
        end
    end

endmodule
